// File: rtl/flow_ctrl_pkg.sv
// Shared helpers for the fixed-latency flow controller: counter/pointer width
// functions and the assertion macro used for the credit bookkeeping checks.
`ifndef FLOW_CTRL_PKG_SV
`define FLOW_CTRL_PKG_SV

`define FLOW_CTRL_ASSERT(clk, rst_n, cond) \
  assert property (@(posedge clk) disable iff (!rst_n) (cond))

package flow_ctrl_pkg;

  // Bits needed to hold 0..n inclusive (credit counter, occupancy).
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed to index DEPTH entries; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

`endif

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: rd_data always presents the head entry, and the
// pointers carry an extra wrap bit so full/empty need no separate counter.
module sync_fifo_sa
  import flow_ctrl_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full
);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          wr_ok;
  logic          rd_ok;

  // Index wraps at DEPTH (not a power of two in general); the MSB flips on wrap.
  function automatic logic [AW:0] ptr_next(input logic [AW:0] p);
    if (p[AW-1:0] == LAST) return {~p[AW], {AW{1'b0}}};
    return {p[AW], p[AW-1:0] + AW'(1)};
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_next(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_next(rd_ptr);
    end
  end

endmodule

// File: rtl/fixed_latency_flow_ctrl.sv
// Credit-based valid/ready wrapper around a stall-free datapath of fixed depth:
// beats are admitted only when an output FIFO slot is already reserved for them.
module fixed_latency_flow_ctrl
  import flow_ctrl_pkg::*;
#(
  parameter int  LATENCY = 2,
  parameter int  DW      = 32,
  parameter int  DEPTH   = 4,
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          pipe_in_en,
  output logic [DW-1:0] pipe_in_data,
  input  logic [DW-1:0] pipe_out_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [CW-1:0] credit_cnt,
  output logic          busy
);
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

  logic          init_done;
  logic          acc;
  logic          pop;
  logic          tail;
  logic          in_flight;
  logic          fifo_wr;
  logic          fifo_empty;
  logic          fifo_full;
  logic [DW-1:0] fifo_head;
  logic [CW-1:0] occ;
  int            fly_cnt;

  // s_ready depends only on registers and flush, so m_ready never reaches it.
  assign s_ready      = init_done & (credit_cnt != '0) & ~flush;
  assign acc          = s_valid & s_ready;
  assign pop          = m_valid & m_ready;
  assign pipe_in_en   = acc;
  assign pipe_in_data = s_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) init_done <= 1'b0;
    else        init_done <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              credit_cnt <= CRED_MAX;
    else if (flush)          credit_cnt <= CRED_MAX;
    else if (acc && !pop)    credit_cnt <= credit_cnt - CW'(1);
    else if (pop && !acc)    credit_cnt <= credit_cnt + CW'(1);
  end

  generate
    if (LATENCY == 0) begin : g_lat0
      assign tail      = acc;
      assign in_flight = 1'b0;
      assign fly_cnt   = 0;
    end else begin : g_vsr
      logic [LATENCY-1:0] vsr;

      // Stage boundary: one bit per datapath stage marks a live beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vsr <= '0;
        else if (flush) vsr <= '0;
        else            vsr <= (vsr << 1) | LATENCY'(acc);
      end

      assign tail      = vsr[LATENCY-1];
      assign in_flight = |vsr;
      assign fly_cnt   = $countones(vsr);
    end
  endgenerate

  assign fifo_wr = tail & ~flush;

  sync_fifo_sa #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (fifo_wr),
    .wr_data (pipe_out_data),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = m_valid ? fifo_head : '0;
  assign busy    = in_flight | ~fifo_empty;

  // Shadow occupancy, kept only so the credit invariant can be checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               occ <= '0;
    else if (flush)           occ <= '0;
    else if (fifo_wr && !pop) occ <= occ + CW'(1);
    else if (pop && !fifo_wr) occ <= occ - CW'(1);
  end

  `FLOW_CTRL_ASSERT(clk, rst_n, int'(credit_cnt) + fly_cnt + int'(occ) == DEPTH);
  `FLOW_CTRL_ASSERT(clk, rst_n, !(pop && !acc && !flush && credit_cnt == CRED_MAX));
  `FLOW_CTRL_ASSERT(clk, rst_n, !(acc && !pop && credit_cnt == '0));
  `FLOW_CTRL_ASSERT(clk, rst_n, !(fifo_wr && fifo_full && !pop));

endmodule
